// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO bank.
// Holds the bus data width, the default INFO identifier, the register
// byte offsets, the register-select encoding (adr_i[4:2]) and a helper that
// expands Wishbone byte enables into a per-bit lane mask.
package wb_gpio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;

  localparam logic [15:0] INFO_ID_DEFAULT = 16'h6770;

  localparam logic [4:0] OFS_OUT      = 5'h00;
  localparam logic [4:0] OFS_OE       = 5'h04;
  localparam logic [4:0] OFS_IN       = 5'h08;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFS_IRQ_RISE = 5'h10;
  localparam logic [4:0] OFS_IRQ_STAT = 5'h14;
  localparam logic [4:0] OFS_INFO     = 5'h18;
  localparam logic [4:0] OFS_RSVD     = 5'h1C;

  // Word index of each register, i.e. adr_i[4:2].
  typedef enum logic [2:0] {
    REG_OUT      = 3'd0,
    REG_OE       = 3'd1,
    REG_IN       = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_IRQ_RISE = 3'd4,
    REG_IRQ_STAT = 3'd5,
    REG_INFO     = 3'd6,
    REG_RSVD     = 3'd7
  } reg_sel_e;

  function automatic logic [DATA_W-1:0] byte_lane_mask(input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_bank_sync_edge.sv
// gpio_sync_edge: two-flop synchroniser for asynchronous pad inputs plus a
// third flop holding the previous synchronised value, used to detect edges.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears every flop
//   async_i : asynchronous pad inputs
//   sync_o  : second-stage synchronised value
//   rise_o  : registered one-cycle pulse per bit on a 0->1 transition
//   fall_o  : registered one-cycle pulse per bit on a 1->0 transition
module gpio_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Edge pulses are registered, so a pad change captured at edge k is
  // visible as a pulse after edge k+2 and can set status at edge k+3.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_o <= sync_q & ~prev_q;
      fall_o <= ~sync_q & prev_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone-classic slave with NUM_CH GPIO channels, per-channel
// output/enable registers, synchronised inputs and edge interrupts.
//   clk_i, rst_i            : clock and synchronous active-high reset
//   adr_i, dat_i, dat_o     : byte address (adr_i[4:2] selects), write/read data
//   sel_i, we_i, stb_i, cyc_i, ack_o : Wishbone classic control
//   gpio_i                  : asynchronous pad inputs
//   gpio_o, gpio_oe         : pad output value and output enable
//   irq_o                   : registered level interrupt
module wb_gpio_bank
  import wb_gpio_pkg::*;
#(
  parameter int unsigned NUM_CH  = 8,
  parameter logic [15:0] INFO_ID = INFO_ID_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  output logic              ack_o,
  input  logic [NUM_CH-1:0] gpio_i,
  output logic [NUM_CH-1:0] gpio_o,
  output logic [NUM_CH-1:0] gpio_oe,
  output logic              irq_o
);

  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  logic [NUM_CH-1:0] out_q, oe_q, en_q, rise_sel_q, stat_q;
  logic [NUM_CH-1:0] out_d, oe_d, en_d, rise_sel_d, stat_d;
  logic [NUM_CH-1:0] sync_val, rise_ev, fall_ev;
  logic [NUM_CH-1:0] wmask, wdat;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] rd_data;
  logic              req, wr, rd;
  reg_sel_e          rsel;
  logic              unused_bits;

  gpio_sync_edge #(.WIDTH(NUM_CH)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(gpio_i),
    .sync_o (sync_val),
    .rise_o (rise_ev),
    .fall_o (fall_ev)
  );

  // ack_o gates the request, so a held strobe is served every other cycle.
  assign req  = stb_i & cyc_i & ~ack_o;
  assign wr   = req & we_i;
  assign rd   = req & ~we_i;
  assign rsel = reg_sel_e'(adr_i[4:2]);

  assign lane_mask = byte_lane_mask(sel_i);
  assign wmask     = lane_mask[NUM_CH-1:0];
  assign wdat      = dat_i[NUM_CH-1:0];

  // Byte-lane and upper data bits beyond NUM_CH have no destination.
  assign unused_bits = ^{adr_i[1:0], dat_i, lane_mask};

  always_comb begin
    out_d      = out_q;
    oe_d       = oe_q;
    en_d       = en_q;
    rise_sel_d = rise_sel_q;
    stat_d     = stat_q;
    if (wr) begin
      case (rsel)
        REG_OUT:      out_d      = (out_q & ~wmask) | (wdat & wmask);
        REG_OE:       oe_d       = (oe_q & ~wmask) | (wdat & wmask);
        REG_IRQ_EN:   en_d       = (en_q & ~wmask) | (wdat & wmask);
        REG_IRQ_RISE: rise_sel_d = (rise_sel_q & ~wmask) | (wdat & wmask);
        REG_IRQ_STAT: stat_d     = stat_q & ~(wdat & wmask);
        default:      ;
      endcase
    end
    // Set is applied after the W1C clear so a coincident event wins.
    stat_d = stat_d | (en_q & ((rise_sel_q & rise_ev) | (~rise_sel_q & fall_ev)));
  end

  always_comb begin
    rd_data = '0;
    case (rsel)
      REG_OUT:      rd_data = DATA_W'(out_q);
      REG_OE:       rd_data = DATA_W'(oe_q);
      REG_IN:       rd_data = DATA_W'(sync_val);
      REG_IRQ_EN:   rd_data = DATA_W'(en_q);
      REG_IRQ_RISE: rd_data = DATA_W'(rise_sel_q);
      REG_IRQ_STAT: rd_data = DATA_W'(stat_q);
      REG_INFO:     rd_data = {INFO_ID, 8'h00, NUM_CH_B};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o      <= 1'b0;
      dat_o      <= '0;
      irq_o      <= 1'b0;
      out_q      <= '0;
      oe_q       <= '0;
      en_q       <= '0;
      rise_sel_q <= '0;
      stat_q     <= '0;
    end else begin
      ack_o      <= req;
      if (rd) begin
        dat_o <= rd_data;
      end
      out_q      <= out_d;
      oe_q       <= oe_d;
      en_q       <= en_d;
      rise_sel_q <= rise_sel_d;
      stat_q     <= stat_d;
      irq_o      <= |(stat_q & en_q);
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = oe_q;

endmodule
